pu_tag_lookup_engine: RTL and testbench

Requester-side lookup engine for the processing unit's tag tables. It accepts one tag key at a time and issues parallel bucket reads to tag hash table 0 and tag hash table 1. It compares the stored keys against the request and, on a hit, fetches the tag value entry. The result is returned over a valid/ready response interface. It drives the `tag_hash_table0/1_rd` and `tag_value_rd` request ports of `pu_tag_lookup_mem` and consumes their ack/rdata returns.

---
 rtl/pu_tag_lookup_engine.sv | 170 +++++++++++++++++
 tb/tb_pu_tag_lookup_engine.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_tag_lookup_engine.sv
// Tag lookup requester: reads a bucket from each hash table, compares both against the key,
// fetches the value entry on a hit and returns the result over a valid/ready response.
module pu_tag_lookup_engine #(
   parameter int unsigned DEPTH_NBITS       = 10,
   parameter int unsigned KEY_NBITS         = 32,
   parameter int unsigned VALUE_DEPTH_NBITS = 10,
   parameter int unsigned VALUE_NBITS       = 64,
   parameter int unsigned BUCKET_NBITS      = 1 + KEY_NBITS + VALUE_DEPTH_NBITS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tag_lookup_req,
   input  logic [KEY_NBITS-1:0]         tag_lookup_key,
   output logic                         tag_lookup_req_ready,
   output logic                         tag_hash_table0_rd,
   output logic [DEPTH_NBITS-1:0]       tag_hash_table0_raddr,
   output logic                         tag_hash_table1_rd,
   output logic [DEPTH_NBITS-1:0]       tag_hash_table1_raddr,
   input  logic                         tag_hash_table0_ack,
   input  logic [BUCKET_NBITS-1:0]      tag_hash_table0_rdata,
   input  logic                         tag_hash_table1_ack,
   input  logic [BUCKET_NBITS-1:0]      tag_hash_table1_rdata,
   output logic                         tag_value_rd,
   output logic [VALUE_DEPTH_NBITS-1:0] tag_value_raddr,
   input  logic                         tag_value_ack,
   input  logic [VALUE_NBITS-1:0]       tag_value_rdata,
   output logic                         tag_lookup_rsp_valid,
   input  logic                         tag_lookup_rsp_ready,
   output logic                         tag_lookup_rsp_hit,
   output logic                         tag_lookup_rsp_table,
   output logic [VALUE_DEPTH_NBITS-1:0] tag_lookup_rsp_vidx,
   output logic [VALUE_NBITS-1:0]       tag_lookup_rsp_value
);

   typedef enum logic [2:0] {
      S_IDLE, S_HRD, S_HWAIT, S_CMP, S_VRD, S_VWAIT, S_RSP
   } state_t;

   state_t                         state_q;
   logic [KEY_NBITS-1:0]           key_q;
   logic [BUCKET_NBITS-1:0]        bkt0_q, bkt1_q;
   logic                           seen0_q, seen1_q;
   logic                           win_tbl_q;
   logic                           req_ready_q;
   logic                           rd0_q, rd1_q, vrd_q;
   logic [DEPTH_NBITS-1:0]         raddr0_q, raddr1_q;
   logic [VALUE_DEPTH_NBITS-1:0]   vraddr_q;
   logic                           rsp_valid_q, rsp_hit_q, rsp_table_q;
   logic [VALUE_DEPTH_NBITS-1:0]   rsp_vidx_q;
   logic [VALUE_NBITS-1:0]         rsp_value_q;

   // Hashes taken from the key on the accept edge, i.e. the value being latched.
   logic [DEPTH_NBITS-1:0] h0_c, h1_c;
   assign h0_c = tag_lookup_key[DEPTH_NBITS-1:0];
   assign h1_c = tag_lookup_key[2*DEPTH_NBITS-1:DEPTH_NBITS]
               ^ tag_lookup_key[KEY_NBITS-1:KEY_NBITS-DEPTH_NBITS];

   logic hit0_c, hit1_c, seen0_c, seen1_c;
   assign hit0_c  = bkt0_q[BUCKET_NBITS-1] &&
                    (bkt0_q[BUCKET_NBITS-2:VALUE_DEPTH_NBITS] == key_q);
   assign hit1_c  = bkt1_q[BUCKET_NBITS-1] &&
                    (bkt1_q[BUCKET_NBITS-2:VALUE_DEPTH_NBITS] == key_q);
   assign seen0_c = seen0_q | tag_hash_table0_ack;
   assign seen1_c = seen1_q | tag_hash_table1_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         key_q       <= '0;
         bkt0_q      <= '0;
         bkt1_q      <= '0;
         seen0_q     <= 1'b0;
         seen1_q     <= 1'b0;
         win_tbl_q   <= 1'b0;
         req_ready_q <= 1'b1;
         rd0_q       <= 1'b0;
         rd1_q       <= 1'b0;
         vrd_q       <= 1'b0;
         raddr0_q    <= '0;
         raddr1_q    <= '0;
         vraddr_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_table_q <= 1'b0;
         rsp_vidx_q  <= '0;
         rsp_value_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tag_lookup_req) begin
                  key_q       <= tag_lookup_key;
                  seen0_q     <= 1'b0;
                  seen1_q     <= 1'b0;
                  rd0_q       <= 1'b1;
                  rd1_q       <= 1'b1;
                  raddr0_q    <= h0_c;
                  raddr1_q    <= h1_c;
                  req_ready_q <= 1'b0;
                  state_q     <= S_HRD;
               end
            end
            S_HRD: begin
               rd0_q   <= 1'b0;
               rd1_q   <= 1'b0;
               state_q <= S_HWAIT;
            end
            S_HWAIT: begin
               if (tag_hash_table0_ack && !seen0_q) bkt0_q <= tag_hash_table0_rdata;
               if (tag_hash_table1_ack && !seen1_q) bkt1_q <= tag_hash_table1_rdata;
               seen0_q <= seen0_c;
               seen1_q <= seen1_c;
               if (seen0_c && seen1_c) state_q <= S_CMP;
            end
            S_CMP: begin
               // Table 0 takes priority when both buckets match.
               if (hit0_c || hit1_c) begin
                  win_tbl_q <= !hit0_c;
                  vraddr_q  <= hit0_c ? bkt0_q[VALUE_DEPTH_NBITS-1:0]
                                      : bkt1_q[VALUE_DEPTH_NBITS-1:0];
                  vrd_q     <= 1'b1;
                  state_q   <= S_VRD;
               end else begin
                  rsp_valid_q <= 1'b1;
                  rsp_hit_q   <= 1'b0;
                  rsp_table_q <= 1'b0;
                  rsp_vidx_q  <= '0;
                  rsp_value_q <= '0;
                  state_q     <= S_RSP;
               end
            end
            S_VRD: begin
               vrd_q   <= 1'b0;
               state_q <= S_VWAIT;
            end
            S_VWAIT: begin
               if (tag_value_ack) begin
                  rsp_valid_q <= 1'b1;
                  rsp_hit_q   <= 1'b1;
                  rsp_table_q <= win_tbl_q;
                  rsp_vidx_q  <= vraddr_q;
                  rsp_value_q <= tag_value_rdata;
                  state_q     <= S_RSP;
               end
            end
            S_RSP: begin
               if (tag_lookup_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign tag_lookup_req_ready  = req_ready_q;
   assign tag_hash_table0_rd    = rd0_q;
   assign tag_hash_table0_raddr = raddr0_q;
   assign tag_hash_table1_rd    = rd1_q;
   assign tag_hash_table1_raddr = raddr1_q;
   assign tag_value_rd          = vrd_q;
   assign tag_value_raddr       = vraddr_q;
   assign tag_lookup_rsp_valid  = rsp_valid_q;
   assign tag_lookup_rsp_hit    = rsp_hit_q;
   assign tag_lookup_rsp_table  = rsp_table_q;
   assign tag_lookup_rsp_vidx   = rsp_vidx_q;
   assign tag_lookup_rsp_value  = rsp_value_q;

endmodule

// File: tb/tb_pu_tag_lookup_engine.sv
// Directed bench for pu_tag_lookup_engine with a variable-latency memory model.
module tb_pu_tag_lookup_engine;
   localparam int unsigned DW = 10;
   localparam int unsigned KW = 32;
   localparam int unsigned VDW = 10;
   localparam int unsigned VW = 64;
   localparam int unsigned BW = 1 + KW + VDW;

   logic clk = 1'b0;
   logic rst;
   logic req, req_ready, rd0, rd1, ack0, ack1, vrd, vack;
   logic [KW-1:0] key;
   logic [DW-1:0] raddr0, raddr1;
   logic [BW-1:0] rdata0, rdata1;
   logic [VDW-1:0] vraddr, rsp_vidx;
   logic [VW-1:0] vrdata, rsp_value;
   logic rsp_valid, rsp_ready, rsp_hit, rsp_table;

   always #5 clk = ~clk;

   pu_tag_lookup_engine dut (
      .clk(clk), .rst(rst),
      .tag_lookup_req(req), .tag_lookup_key(key), .tag_lookup_req_ready(req_ready),
      .tag_hash_table0_rd(rd0), .tag_hash_table0_raddr(raddr0),
      .tag_hash_table1_rd(rd1), .tag_hash_table1_raddr(raddr1),
      .tag_hash_table0_ack(ack0), .tag_hash_table0_rdata(rdata0),
      .tag_hash_table1_ack(ack1), .tag_hash_table1_rdata(rdata1),
      .tag_value_rd(vrd), .tag_value_raddr(vraddr),
      .tag_value_ack(vack), .tag_value_rdata(vrdata),
      .tag_lookup_rsp_valid(rsp_valid), .tag_lookup_rsp_ready(rsp_ready),
      .tag_lookup_rsp_hit(rsp_hit), .tag_lookup_rsp_table(rsp_table),
      .tag_lookup_rsp_vidx(rsp_vidx), .tag_lookup_rsp_value(rsp_value)
   );

   // Memory model: ack lat cycles after the rd pulse, data from the address captured with rd.
   logic [BW-1:0] t0 [1024];
   logic [BW-1:0] t1 [1024];
   logic [VW-1:0] vmem [1024];
   int lat0 = 2, lat1 = 2, latv = 2;
   logic [15:0] p0 = '0, p1 = '0, pv = '0;
   logic [DW-1:0] a0 = '0, a1 = '0;
   logic [VDW-1:0] av = '0;

   always @(posedge clk) begin
      p0 <= {p0[14:0], rd0};
      p1 <= {p1[14:0], rd1};
      pv <= {pv[14:0], vrd};
      if (rd0) a0 <= raddr0;
      if (rd1) a1 <= raddr1;
      if (vrd) av <= vraddr;
   end
   assign ack0   = p0[4'(lat0 - 1)];
   assign ack1   = p1[4'(lat1 - 1)];
   assign vack   = pv[4'(latv - 1)];
   assign rdata0 = t0[a0];
   assign rdata1 = t1[a1];
   assign vrdata = vmem[av];

   int tests_run = 0;
   int tests_failed = 0;

   int obs_tvalid, obs_tvrd, n_rd0, n_rd1, n_vrd;
   logic [DW-1:0] obs_ra0, obs_ra1;
   logic [VDW-1:0] obs_vra, obs_vidx;
   logic obs_hit, obs_tbl, obs_ready_after;
   logic [VW-1:0] obs_val;

   // Stimulus only: issue one lookup with rsp_ready high and record what the DUT did.
   task automatic run_lookup(input logic [KW-1:0] k);
      int cyc;
      bit done;
      obs_tvalid = -1; obs_tvrd = -1; n_rd0 = 0; n_rd1 = 0; n_vrd = 0;
      obs_ra0 = 'x; obs_ra1 = 'x; obs_vra = 'x;
      obs_hit = 'x; obs_tbl = 'x; obs_vidx = 'x; obs_val = 'x; obs_ready_after = 'x;
      rsp_ready = 1'b1;
      @(negedge clk);
      cyc = 0;
      while (!req_ready && cyc < 50) begin @(negedge clk); cyc++; end
      req = 1'b1; key = k;
      @(negedge clk);
      req = 1'b0;
      cyc = 1; done = 0;
      while (!done && cyc < 80) begin
         if (rd0) begin n_rd0++; obs_ra0 = raddr0; end
         if (rd1) begin n_rd1++; obs_ra1 = raddr1; end
         if (vrd) begin n_vrd++; obs_tvrd = cyc; obs_vra = vraddr; end
         if (rsp_valid) begin
            obs_tvalid = cyc; obs_hit = rsp_hit; obs_tbl = rsp_table;
            obs_vidx = rsp_vidx; obs_val = rsp_value; done = 1;
         end else begin
            @(negedge clk); cyc++;
         end
      end
      @(negedge clk);
      obs_ready_after = req_ready;
   endtask

   task automatic test_reset();
      tests_run++;
      if ({req_ready, rd0, rd1, vrd, rsp_valid} !== 5'b10000) begin
         tests_failed++; $display("FAIL reset.ctl got %b exp 10000", {req_ready, rd0, rd1, vrd, rsp_valid});
      end
      tests_run++;
      if ({raddr0, raddr1, vraddr} !== '0) begin
         tests_failed++; $display("FAIL reset.raddr got %h/%h/%h exp 0", raddr0, raddr1, vraddr);
      end
      tests_run++;
      if ({rsp_hit, rsp_table, rsp_vidx, rsp_value} !== '0) begin
         tests_failed++; $display("FAIL reset.rsp got %b %b %h %h exp 0", rsp_hit, rsp_table, rsp_vidx, rsp_value);
      end
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         tests_failed++; $display("FAIL reset.release got ready=%b valid=%b exp 1 0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_hit_t0();
      t0[10'h234] = {1'b1, 32'h0000_1234, 10'h05A};
      t1[10'h004] = '0;
      vmem[10'h05A] = 64'hDEADBEEF_CAFEF00D;
      run_lookup(32'h0000_1234);
      tests_run++;
      if (obs_ra0 !== 10'h234 || obs_ra1 !== 10'h004) begin
         tests_failed++; $display("FAIL hit_t0.raddr got %h %h exp 234 004", obs_ra0, obs_ra1);
      end
      tests_run++;
      if (obs_hit !== 1'b1 || obs_tbl !== 1'b0 || obs_vidx !== 10'h05A) begin
         tests_failed++; $display("FAIL hit_t0.rsp got hit=%b tbl=%b vidx=%h exp 1 0 05a", obs_hit, obs_tbl, obs_vidx);
      end
      tests_run++;
      if (obs_val !== 64'hDEADBEEF_CAFEF00D) begin
         tests_failed++; $display("FAIL hit_t0.value got %h exp deadbeefcafef00d", obs_val);
      end
      tests_run++;
      if (obs_tvalid !== 8 || obs_tvrd !== 5 || obs_vra !== 10'h05A) begin
         tests_failed++; $display("FAIL hit_t0.timing got valid@%0d vrd@%0d vra=%h exp 8 5 05a", obs_tvalid, obs_tvrd, obs_vra);
      end
      tests_run++;
      if (obs_ready_after !== 1'b1) begin
         tests_failed++; $display("FAIL hit_t0.ready_after got %b exp 1", obs_ready_after);
      end
   endtask

   task automatic test_hit_t1();
      t0[10'h234] = {1'b1, 32'h0000_5678, 10'h011};
      t1[10'h004] = {1'b1, 32'h0000_1234, 10'h3FF};
      vmem[10'h3FF] = 64'h0123_4567_89AB_CDEF;
      run_lookup(32'h0000_1234);
      tests_run++;
      if (obs_hit !== 1'b1 || obs_tbl !== 1'b1 || obs_vidx !== 10'h3FF || obs_val !== 64'h0123_4567_89AB_CDEF) begin
         tests_failed++; $display("FAIL hit_t1.rsp got %b %b %h %h exp 1 1 3ff 0123456789abcdef", obs_hit, obs_tbl, obs_vidx, obs_val);
      end
   endtask

   task automatic test_both_hit();
      t0[10'h234] = {1'b1, 32'h0000_1234, 10'h05A};
      t1[10'h004] = {1'b1, 32'h0000_1234, 10'h3FF};
      run_lookup(32'h0000_1234);
      tests_run++;
      if (obs_hit !== 1'b1 || obs_tbl !== 1'b0 || obs_vidx !== 10'h05A || obs_val !== 64'hDEADBEEF_CAFEF00D) begin
         tests_failed++; $display("FAIL both_hit.rsp got %b %b %h %h exp 1 0 05a deadbeefcafef00d", obs_hit, obs_tbl, obs_vidx, obs_val);
      end
   endtask

   task automatic test_miss();
      // Matching keys but valid=0 in both buckets.
      t0[10'h123] = {1'b0, 32'hABCD_E123, 10'h011};
      t1[10'h1D7] = {1'b0, 32'hABCD_E123, 10'h022};
      run_lookup(32'hABCD_E123);
      tests_run++;
      if (obs_ra0 !== 10'h123 || obs_ra1 !== 10'h1D7) begin
         tests_failed++; $display("FAIL miss.raddr got %h %h exp 123 1d7", obs_ra0, obs_ra1);
      end
      tests_run++;
      if (n_vrd !== 0) begin
         tests_failed++; $display("FAIL miss.value_rd got %0d pulses exp 0", n_vrd);
      end
      tests_run++;
      if (obs_hit !== 1'b0 || obs_tbl !== 1'b0 || obs_vidx !== '0 || obs_val !== '0) begin
         tests_failed++; $display("FAIL miss.rsp got %b %b %h %h exp all 0", obs_hit, obs_tbl, obs_vidx, obs_val);
      end
      tests_run++;
      if (obs_tvalid !== 5) begin
         tests_failed++; $display("FAIL miss.timing got valid@%0d exp 5", obs_tvalid);
      end
   endtask

   task automatic test_skew();
      t0[10'h234] = {1'b1, 32'h0000_1234, 10'h05A};
      t1[10'h004] = '0;
      lat0 = 5; lat1 = 1;
      run_lookup(32'h0000_1234);
      lat0 = 2; lat1 = 2;
      tests_run++;
      if (n_rd0 !== 1 || n_rd1 !== 1 || n_vrd !== 1) begin
         tests_failed++; $display("FAIL skew.reads got %0d %0d %0d exp 1 1 1", n_rd0, n_rd1, n_vrd);
      end
      tests_run++;
      if (obs_tvrd !== 8 || obs_tvalid !== 11) begin
         tests_failed++; $display("FAIL skew.timing got vrd@%0d valid@%0d exp 8 11", obs_tvrd, obs_tvalid);
      end
      tests_run++;
      if (obs_hit !== 1'b1 || obs_tbl !== 1'b0 || obs_val !== 64'hDEADBEEF_CAFEF00D) begin
         tests_failed++; $display("FAIL skew.rsp got %b %b %h exp 1 0 deadbeefcafef00d", obs_hit, obs_tbl, obs_val);
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      int bad;
      t0[10'h234] = {1'b1, 32'h0000_1234, 10'h05A};
      rsp_ready = 1'b0;
      @(negedge clk);
      req = 1'b1; key = 32'h0000_1234;
      cyc = 0;
      while (!rsp_valid && cyc < 60) begin @(negedge clk); cyc++; end
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_table !== 1'b0 || rsp_vidx !== 10'h05A ||
             rsp_value !== 64'hDEADBEEF_CAFEF00D || req_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++; $display("FAIL backpressure.stable got %0d bad cycles exp 0", bad);
      end
      rsp_ready = 1'b1;
      tests_run++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
         tests_failed++; $display("FAIL backpressure.handshake got valid=%b ready=%b exp 1 0", rsp_valid, req_ready);
      end
      @(negedge clk);
      tests_run++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         tests_failed++; $display("FAIL backpressure.after got ready=%b valid=%b exp 1 0", req_ready, rsp_valid);
      end
      @(negedge clk);
      tests_run++;
      if (req_ready !== 1'b0) begin
         tests_failed++; $display("FAIL backpressure.reaccept got ready=%b exp 0", req_ready);
      end
      req = 1'b0;
      cyc = 0;
      while (!rsp_valid && cyc < 60) begin @(negedge clk); cyc++; end
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_vidx !== 10'h05A) begin
         tests_failed++; $display("FAIL backpressure.second got valid=%b hit=%b vidx=%h exp 1 1 05a", rsp_valid, rsp_hit, rsp_vidx);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_vwait();
      int cyc;
      int bad;
      t0[10'h234] = {1'b1, 32'h0000_1234, 10'h05A};
      latv = 6;
      rsp_ready = 1'b1;
      @(negedge clk);
      req = 1'b1; key = 32'h0000_1234;
      @(negedge clk);
      req = 1'b0;
      cyc = 0;
      while (!vrd && cyc < 40) begin @(negedge clk); cyc++; end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({req_ready, rd0, rd1, vrd, rsp_valid, rsp_hit, rsp_table} !== 7'b1000000 ||
          {raddr0, raddr1, vraddr, rsp_vidx, rsp_value} !== '0) begin
         tests_failed++; $display("FAIL reset_vwait.outputs got ready=%b valid=%b vra=%h exp reset values", req_ready, rsp_valid, vraddr);
      end
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++; $display("FAIL reset_vwait.late_ack got %0d bad cycles exp 0", bad);
      end
      latv = 2;
      run_lookup(32'h0000_1234);
      tests_run++;
      if (obs_hit !== 1'b1 || obs_vidx !== 10'h05A || obs_val !== 64'hDEADBEEF_CAFEF00D || obs_tvalid !== 8) begin
         tests_failed++; $display("FAIL reset_vwait.next got hit=%b vidx=%h val=%h valid@%0d exp 1 05a deadbeefcafef00d 8", obs_hit, obs_vidx, obs_val, obs_tvalid);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin t0[i] = '0; t1[i] = '0; vmem[i] = '0; end
      rst = 1'b1; req = 1'b0; key = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_hit_t0();
      test_hit_t1();
      test_both_hit();
      test_miss();
      test_skew();
      test_backpressure();
      test_reset_vwait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
